// File: rtl/datamem_responder.sv
// Byte-addressed data memory behind a valid/ready request/response handshake.
// One request in flight at a time; the response appears LATENCY cycles after acceptance.
module datamem_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_xfer_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_reset_q;

    logic          wr_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [2:0]    size_q;

    logic [63:0]   rdata_q, rdata_d;
    logic          err_q;

    logic          accept;
    logic          commit;
    logic          err;
    logic [3:0]    nbytes;
    logic [AW-1:0] base;

    logic [7:0]    mem [DEPTH_BYTES];

    assign accept = req_valid && req_ready;
    // Gated by rst so a store caught by reset on its commit edge is dropped.
    assign commit = rst && (state_q == StBusy) && (cnt_q == '0);
    assign base   = addr_q[AW-1:0];

    always_comb begin
        case (size_q)
            3'd0:    nbytes = 4'd8;
            3'd1:    nbytes = 4'd1;
            3'd2:    nbytes = 4'd2;
            3'd4:    nbytes = 4'd4;
            default: nbytes = 4'd0;
        endcase
    end

    // Bound check is done as addr > DEPTH - n so no upper address bits are lost to overflow.
    always_comb begin
        err = 1'b0;
        if (nbytes == 4'd0) begin
            err = 1'b1;
        end else if ((addr_q[3:0] & (nbytes - 4'd1)) != 4'd0) begin
            err = 1'b1;
        end else if (addr_q > (64'(DEPTH_BYTES) - 64'(nbytes))) begin
            err = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                rdata_d[8*i +: 8] = mem[base + AW'(i)];
            end
        end
        if (err || wr_q) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && wr_q && !err) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nbytes) begin
                    mem[base + AW'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_xfer_size;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            in_reset_q <= 1'b1;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_reset_q <= 1'b0;
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StBusy;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle) && !in_reset_q;
        resp_valid = (state_q == StResp);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: doc/datamem_responder.md
# datamem_responder

Handshaked data-memory responder serving the CPU datapath's load/store requests. It holds a byte-addressed memory array, accepts one request at a time over a valid/ready interface, and waits a programmable latency. It then returns a response with read data or an error flag. It is the memory side of the CPU's data-memory port, replacing the fixed-timing memory as the design moves toward multi-cycle and pipelined cores.

## Interface
- DEPTH_BYTES, 1024: size of the memory array in bytes; power of two, multiple of 8.
- LATENCY, 2: cycles from request acceptance to response valid; must be ≥1.
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data; the low bytes are used per the transfer size.
- req_xfer_size  in  3  transfer size: 3'd0 = 8 bytes, 3'd1 = 1, 3'd2 = 2, 3'd4 = 4; all other codes are illegal.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  64  load data, zero-extended; 0 for stores and errors.
- resp_err  out  1  request was rejected and memory is unchanged.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid, the request is accepted and its fields are latched. The FSM goes to BUSY with the counter set to LATENCY-1.
- **BUSY**
  - req_ready = 0.
  - The counter decrements each cycle.
  - When the counter is 0, the latched request executes and the FSM goes to RESP.
- **RESP**
  - resp_valid = 1.
  - resp_rdata and resp_err stay stable until resp_ready is sampled high, then the FSM returns to IDLE.
  - resp_ready is ignored in every state other than RESP.
- **Error checks** are evaluated on the latched request:
  - illegal size code;
  - address not a multiple of the transfer size;
  - addr + size > DEPTH_BYTES, using full 64-bit compare with no truncation of upper address bits.
  - Any check failing gives resp_err = 1 and resp_rdata = 0, and no byte is written.
- **Byte order** is little-endian. Byte addr maps to bits [7:0], addr+1 to [15:8], and so on.
  - Loads zero-extend into resp_rdata.
  - Stores write only the addressed bytes; all other bytes are unchanged.
- The write commit and the read sampling both happen on the BUSY→RESP edge.
- **Reset**
  - Outputs: req_ready = 0 while reset is asserted, 1 in the first cycle after release; resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - The FSM returns to IDLE and the counter clears.
  - Memory contents are not cleared.
  - Reset in BUSY aborts the request: a store not yet committed is never committed.
  - Reset in RESP drops the response.
- The latched request is independent of the request inputs after acceptance. Changes to req_* during BUSY or RESP have no effect.

## Timing
- Acceptance occurs on edge T, with req_valid & req_ready sampled high.
- resp_valid rises after edge T+LATENCY.
- Minimum request-to-request spacing is LATENCY+2 cycles: acceptance, LATENCY cycles in BUSY, then one cycle in RESP with resp_ready already high.
- req_ready returns high the cycle after the response handshake. There is no same-cycle response-plus-accept.
- A store followed by a load to the same address returns the stored data; no forwarding hazard exists because requests are serialized.
- The read path is registered. No output depends combinationally on an input.

## Test plan
- **Reset**
  - Stimulus: hold rst=0 for 3 cycles, then release.
  - Required: during reset req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0. In the first cycle after release req_ready=1.
- **Doubleword round trip** (LATENCY=2)
  - Stimulus: store 64'h0123_4567_89AB_CDEF at addr 16 with size 0, then load addr 16 with size 0.
  - Required: resp_valid rises 2 cycles after each acceptance. The load returns 64'h0123_4567_89AB_CDEF with resp_err=0.
- **Partial store and zero-extension**
  - Stimulus: after the doubleword store above, store byte 8'h5A at addr 17 (size 1).
  - Required: a doubleword load of addr 16 returns 64'h0123_4567_89AB_5AEF. A halfword load of addr 18 returns 64'h0000_0000_0000_89AB.
- **Errors**
  - Stimulus: word store at addr 18; store with size code 3; doubleword store at addr DEPTH_BYTES-4.
  - Required: each gives resp_err=1 and resp_rdata=0. A follow-up load shows memory unchanged.
- **Backpressure**
  - Stimulus: hold resp_ready=0 for 5 cycles after resp_valid rises, and change req_addr and req_wdata during that window.
  - Required: resp_valid, resp_rdata and resp_err stay stable; req_ready=0 throughout; the handshake completes when resp_ready goes high.
- **Reset mid-operation**
  - Stimulus: accept a store to addr 32, then assert rst during BUSY.
  - Required: a subsequent load of addr 32 returns the old contents, and no response is emitted for the aborted store.
